// File: rtl/sample_width_adapter.sv
// Streaming multi-channel sample width converter with an output register and a 1-entry skid.
// Define SAMPLE_WIDTH_ADAPTER_ROUND_EN for round-half-up on left-justified narrowing.
module sample_width_adapter #(
    parameter int  IN_WD     = 16,
    parameter int  OUT_WD    = 24,
    parameter int  NCH       = 2,
    parameter int  LEFT_JUST = 0,
    localparam int CH_WD     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [IN_WD-1:0]  s_data_i,
    input  logic              s_signed_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [OUT_WD-1:0] m_data_o,
    output logic [CH_WD-1:0]  m_chan_o,
    output logic              sat_o
);

    // Both ports: a beat transfers on a rising edge where valid and ready are both high;
    // a raised valid holds with a stable payload until it is accepted.

    localparam logic [CH_WD-1:0] CH_LAST = CH_WD'(NCH - 1);

    logic [OUT_WD-1:0] conv_data;
    logic              conv_sat;
    logic              unused_in;

    assign unused_in = ^{s_signed_i, s_data_i};

    generate
        if (OUT_WD == IN_WD) begin : g_pass
            always_comb begin
                conv_data = s_data_i;
                conv_sat  = 1'b0;
            end
        end else if (OUT_WD > IN_WD) begin : g_widen
            localparam int D = OUT_WD - IN_WD;
            if (LEFT_JUST != 0) begin : g_lj
                always_comb begin
                    conv_data = {s_data_i, {D{1'b0}}};
                    conv_sat  = 1'b0;
                end
            end else begin : g_rj
                logic ext_bit;
                assign ext_bit = s_signed_i & s_data_i[IN_WD-1];
                always_comb begin
                    conv_data = {{D{ext_bit}}, s_data_i};
                    conv_sat  = 1'b0;
                end
            end
        end else begin : g_narrow
            localparam int D = IN_WD - OUT_WD;
            if (LEFT_JUST != 0) begin : g_lj
`ifdef SAMPLE_WIDTH_ADAPTER_ROUND_EN
                localparam logic [IN_WD:0]    HALF  = (IN_WD + 1)'(1) << (D - 1);
                localparam logic [OUT_WD-1:0] MAX_S = {1'b0, {(OUT_WD-1){1'b1}}};
                logic [OUT_WD:0] rnd;
                logic            over;
                always_comb begin
                    rnd  = (OUT_WD + 1)'(({s_signed_i & s_data_i[IN_WD-1], s_data_i} + HALF) >> D);
                    // Only positive overflow is possible: a signed result with top bits 01.
                    over = s_signed_i ? (~rnd[OUT_WD] & rnd[OUT_WD-1]) : rnd[OUT_WD];
                    conv_sat  = over;
                    conv_data = rnd[OUT_WD-1:0];
                    if (over) begin
                        conv_data = s_signed_i ? MAX_S : '1;
                    end
                end
`else
                always_comb begin
                    conv_data = s_data_i[IN_WD-1:D];
                    conv_sat  = 1'b0;
                end
`endif
            end else begin : g_rj
                localparam logic [OUT_WD-1:0] MAX_S = {1'b0, {(OUT_WD-1){1'b1}}};
                localparam logic [OUT_WD-1:0] MIN_S = {1'b1, {(OUT_WD-1){1'b0}}};
                always_comb begin
                    conv_data = s_data_i[OUT_WD-1:0];
                    conv_sat  = 1'b0;
                    if (s_signed_i) begin
                        // Fits only if every bit from the kept sign position upward agrees.
                        if (s_data_i[IN_WD-1:OUT_WD-1] != {(D+1){s_data_i[IN_WD-1]}}) begin
                            conv_sat  = 1'b1;
                            conv_data = s_data_i[IN_WD-1] ? MIN_S : MAX_S;
                        end
                    end else if (|s_data_i[IN_WD-1:OUT_WD]) begin
                        conv_sat  = 1'b1;
                        conv_data = '1;
                    end
                end
            end
        end
    endgenerate

    logic              out_valid;
    logic [OUT_WD-1:0] out_data;
    logic [CH_WD-1:0]  out_chan;
    logic              skid_valid;
    logic [OUT_WD-1:0] skid_data;
    logic [CH_WD-1:0]  skid_chan;
    logic [CH_WD-1:0]  chan_cnt;
    logic              sat_q;
    logic              in_xfer;
    logic              out_free;

    assign s_ready_o = ~skid_valid & ~clr_i & ~rst_i;
    assign in_xfer   = s_valid_i & s_ready_o;
    assign out_free  = ~out_valid | m_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_chan  <= '0;
            chan_cnt   <= '0;
            sat_q      <= 1'b0;
        end else if (clr_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            chan_cnt   <= '0;
            sat_q      <= 1'b0;
        end else begin
            if (in_xfer) begin
                chan_cnt <= (chan_cnt == CH_LAST) ? '0 : chan_cnt + CH_WD'(1);
                if (conv_sat) begin
                    sat_q <= 1'b1;
                end
            end
            if (out_free) begin
                // A waiting skid entry is older than anything arriving now, so it goes first.
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_chan   <= skid_chan;
                    skid_valid <= 1'b0;
                end else if (in_xfer) begin
                    out_valid <= 1'b1;
                    out_data  <= conv_data;
                    out_chan  <= chan_cnt;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_valid <= 1'b1;
                skid_data  <= conv_data;
                skid_chan  <= chan_cnt;
            end
        end
    end

    assign m_valid_o = out_valid;
    assign m_data_o  = out_data;
    assign m_chan_o  = out_chan;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_sample_width_adapter.sv
// Bench for sample_width_adapter: four configurations share one stimulus stream and are
// checked every cycle against an arithmetic model plus hand-computed literal vectors.
`timescale 1ns/1ps
module tb_sample_width_adapter;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_signed = 1'b0;
    logic        m_ready = 1'b0;
    logic [23:0] s_data = '0;

    always #5 clk = ~clk;

    logic        w0_rdy, w0_vld, w0_sat;
    logic [23:0] w0_d;
    logic [0:0]  w0_c;
    logic        w1_rdy, w1_vld, w1_sat;
    logic [23:0] w1_d;
    logic [0:0]  w1_c;
    logic        n1_rdy, n1_vld, n1_sat;
    logic [15:0] n1_d;
    logic [0:0]  n1_c;
    logic        n0_rdy, n0_vld, n0_sat;
    logic [15:0] n0_d;
    logic [1:0]  n0_c;

    sample_width_adapter #(.IN_WD(16), .OUT_WD(24), .NCH(2), .LEFT_JUST(0)) u_w0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .s_valid_i(s_valid), .s_ready_o(w0_rdy),
        .s_data_i(s_data[15:0]), .s_signed_i(s_signed), .m_valid_o(w0_vld),
        .m_ready_i(m_ready), .m_data_o(w0_d), .m_chan_o(w0_c), .sat_o(w0_sat));

    sample_width_adapter #(.IN_WD(16), .OUT_WD(24), .NCH(2), .LEFT_JUST(1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .s_valid_i(s_valid), .s_ready_o(w1_rdy),
        .s_data_i(s_data[15:0]), .s_signed_i(s_signed), .m_valid_o(w1_vld),
        .m_ready_i(m_ready), .m_data_o(w1_d), .m_chan_o(w1_c), .sat_o(w1_sat));

    sample_width_adapter #(.IN_WD(24), .OUT_WD(16), .NCH(2), .LEFT_JUST(1)) u_n1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .s_valid_i(s_valid), .s_ready_o(n1_rdy),
        .s_data_i(s_data), .s_signed_i(s_signed), .m_valid_o(n1_vld),
        .m_ready_i(m_ready), .m_data_o(n1_d), .m_chan_o(n1_c), .sat_o(n1_sat));

    sample_width_adapter #(.IN_WD(24), .OUT_WD(16), .NCH(3), .LEFT_JUST(0)) u_n0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .s_valid_i(s_valid), .s_ready_o(n0_rdy),
        .s_data_i(s_data), .s_signed_i(s_signed), .m_valid_o(n0_vld),
        .m_ready_i(m_ready), .m_data_o(n0_d), .m_chan_o(n0_c), .sat_o(n0_sat));

    logic [23:0] dd [NI];
    logic [1:0]  dc [NI];
    logic        dv [NI];
    logic        dr [NI];
    logic        ds [NI];

    always_comb begin
        dd[0] = w0_d;          dc[0] = {1'b0, w0_c}; dv[0] = w0_vld; dr[0] = w0_rdy; ds[0] = w0_sat;
        dd[1] = w1_d;          dc[1] = {1'b0, w1_c}; dv[1] = w1_vld; dr[1] = w1_rdy; ds[1] = w1_sat;
        dd[2] = {8'h00, n1_d}; dc[2] = {1'b0, n1_c}; dv[2] = n1_vld; dr[2] = n1_rdy; ds[2] = n1_sat;
        dd[3] = {8'h00, n0_d}; dc[3] = n0_c;         dv[3] = n0_vld; dr[3] = n0_rdy; ds[3] = n0_sat;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void inst_cfg(input int i, output int inw, output int outw,
                                     output int lj, output int nch);
        case (i)
            0:       begin inw = 16; outw = 24; lj = 0; nch = 2; end
            1:       begin inw = 16; outw = 24; lj = 1; nch = 2; end
            2:       begin inw = 24; outw = 16; lj = 1; nch = 2; end
            default: begin inw = 24; outw = 16; lj = 0; nch = 3; end
        endcase
    endfunction

    // Conversion as plain integer arithmetic on the numeric value of the sample.
    function automatic void model_conv(input int inw, input int outw, input int lj,
                                       input logic [23:0] raw, input logic sgn,
                                       output logic [23:0] res, output logic sat);
        longint x, v, r, lo, hi;
        int d;
        x = longint'(raw) & ((longint'(1) << inw) - 1);
        v = x;
        if (sgn && (((x >> (inw - 1)) & 1) != 0)) v = x - (longint'(1) << inw);
        sat = 1'b0;
        hi = sgn ? (longint'(1) << (outw - 1)) - 1 : (longint'(1) << outw) - 1;
        lo = sgn ? -(longint'(1) << (outw - 1)) : 0;
        if (outw >= inw) begin
            r = (lj != 0) ? (x << (outw - inw)) : v;
        end else begin
            d = inw - outw;
            if (lj == 0) begin
                r = v;
                if (v > hi) begin r = hi; sat = 1'b1; end
                else if (v < lo) begin r = lo; sat = 1'b1; end
            end else begin
`ifdef SAMPLE_WIDTH_ADAPTER_ROUND_EN
                r = (v + (longint'(1) << (d - 1))) >>> d;
                if (r > hi) begin r = hi; sat = 1'b1; end
`else
                r = v >>> d;
`endif
            end
        end
        res = 24'(r & ((longint'(1) << outw) - 1));
    endfunction

    typedef struct packed {
        logic [NI-1:0][23:0] d;
        logic [NI-1:0][1:0]  c;
    } exp_t;

    exp_t        exp_q[$];
    logic [NI-1:0] m_sat;
    int          m_cnt [NI];

    // Model: samples in flight form a FIFO of at most two (output reg + skid).
    initial begin : model
        int          n, inw, outw, lj, nch;
        bit          in_x, out_x;
        exp_t        e;
        logic [23:0] r;
        logic        s;
        m_sat = '0;
        for (int i = 0; i < NI; i++) m_cnt[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst || clr) begin
                exp_q.delete();
                m_sat = '0;
                for (int i = 0; i < NI; i++) m_cnt[i] = 0;
            end else begin
                n = exp_q.size();
                in_x  = s_valid && (n < 2);
                out_x = (n > 0) && m_ready;
                if (out_x) void'(exp_q.pop_front());
                if (in_x) begin
                    e = '0;
                    for (int i = 0; i < NI; i++) begin
                        inst_cfg(i, inw, outw, lj, nch);
                        model_conv(inw, outw, lj, s_data, s_signed, r, s);
                        e.d[i] = r;
                        e.c[i] = 2'(m_cnt[i]);
                        if (s) m_sat[i] = 1'b1;
                        m_cnt[i] = (m_cnt[i] + 1) % nch;
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("cyc_rdy%0d", i), dr[i], !rst && !clr && (exp_q.size() < 2));
            chk($sformatf("cyc_vld%0d", i), dv[i], exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk($sformatf("cyc_data%0d", i), dd[i], exp_q[0].d[i]);
                chk($sformatf("cyc_chan%0d", i), dc[i], exp_q[0].c[i]);
            end
            chk($sformatf("cyc_sat%0d", i), ds[i], m_sat[i]);
        end
    end

    task automatic do_clr();
        @(posedge clk); #1;
        s_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [23:0] data, input logic sgn,
                           input int idx, input logic [23:0] exp, input logic esat);
        int inw, outw, lj, nch;
        logic [23:0] r;
        logic s;
        inst_cfg(idx, inw, outw, lj, nch);
        model_conv(inw, outw, lj, data, sgn, r, s);
        chk({name, "_model"}, r, exp);
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = data; s_signed = sgn;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk({name, "_vld"}, dv[idx], 1);
        chk({name, "_data"}, dd[idx], exp);
        chk({name, "_sat"}, ds[idx], esat);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [23:0] t5_in  [3];
        logic [23:0] t5_exp [3];
        logic [1:0]  t5_ch  [3];
        logic [23:0] gdat   [3];
        logic [1:0]  gch    [3];
        int          gcyc   [3];
        logic [23:0] mix    [10];
        logic [7:0]  rpat;
        int          k, got;
        logic        r;

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_vld%0d", i), dv[i], 0);
            chk($sformatf("rst_data%0d", i), dd[i], 0);
            chk($sformatf("rst_chan%0d", i), dc[i], 0);
            chk($sformatf("rst_sat%0d", i), ds[i], 0);
            chk($sformatf("rst_rdy%0d", i), dr[i], 0);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", dr[0], 1);

        // 16->24 right-justified
        run_vec("w0_s8000", 24'h008000, 1'b1, 0, 24'hFF8000, 1'b0);
        run_vec("w0_u8000", 24'h008000, 1'b0, 0, 24'h008000, 1'b0);
        run_vec("w0_s7fff", 24'h007FFF, 1'b1, 0, 24'h007FFF, 1'b0);
        // 16->24 left-justified
        run_vec("w1_8000", 24'h008000, 1'b1, 1, 24'h800000, 1'b0);
        run_vec("w1_0001", 24'h000001, 1'b0, 1, 24'h000100, 1'b0);
        // 24->16 left-justified, signed
        do_clr();
`ifdef SAMPLE_WIDTH_ADAPTER_ROUND_EN
        run_vec("n1_123480", 24'h123480, 1'b1, 2, 24'h001235, 1'b0);
        run_vec("n1_12347f", 24'h12347F, 1'b1, 2, 24'h001234, 1'b0);
        run_vec("n1_7fff80", 24'h7FFF80, 1'b1, 2, 24'h007FFF, 1'b1);
`else
        run_vec("n1_123480", 24'h123480, 1'b1, 2, 24'h001234, 1'b0);
        run_vec("n1_12347f", 24'h12347F, 1'b1, 2, 24'h001234, 1'b0);
        run_vec("n1_7fff80", 24'h7FFF80, 1'b1, 2, 24'h007FFF, 1'b0);
`endif
        // 24->16 right-justified saturation and clear
        do_clr();
        run_vec("n0_s010000", 24'h010000, 1'b1, 3, 24'h007FFF, 1'b1);
        run_vec("n0_sff8000", 24'hFF8000, 1'b1, 3, 24'h008000, 1'b1);
        run_vec("n0_u010000", 24'h010000, 1'b0, 3, 24'h00FFFF, 1'b1);
        do_clr();
        @(negedge clk);
        chk("n0_sat_clr", ds[3], 0);

        // Back-pressure: A to output reg, B to skid, C held
        t5_in[0]  = 24'h000011; t5_in[1]  = 24'h008002; t5_in[2]  = 24'h000033;
        t5_exp[0] = 24'h000011; t5_exp[1] = 24'hFF8002; t5_exp[2] = 24'h000033;
        t5_ch[0]  = 2'd0;       t5_ch[1]  = 2'd1;       t5_ch[2]  = 2'd0;
        k = 0; got = 0;
        s_signed = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = t5_in[0];
        for (int cyc = 0; cyc < 16 && got < 3; cyc++) begin
            @(negedge clk);
            r = dr[0];
            if (cyc == 3) begin
                chk("t5_stall_rdy", dr[0], 0);
                chk("t5_stall_vld", dv[0], 1);
                chk("t5_stall_data", dd[0], 24'h000011);
                chk("t5_stall_chan", dc[0], 0);
            end
            if (dv[0] && m_ready) begin
                gdat[got] = dd[0]; gch[got] = dc[0]; gcyc[got] = cyc;
                got++;
            end
            @(posedge clk);
            if (s_valid && r) k++;
            #1;
            if (k < 3) s_data = t5_in[k];
            else s_valid = 1'b0;
            if (cyc == 3) m_ready = 1'b1;
        end
        chk("t5_count", got, 3);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("t5_data%0d", i), gdat[i], t5_exp[i]);
            chk($sformatf("t5_chan%0d", i), gch[i], t5_ch[i]);
            chk($sformatf("t5_cycle%0d", i), gcyc[i] - gcyc[0], i);
        end

        // Mixed stream with a fixed downstream ready pattern
        mix[0] = 24'h000000; mix[1] = 24'h7FFFFF; mix[2] = 24'h800000; mix[3] = 24'hFFFFFF;
        mix[4] = 24'h008000; mix[5] = 24'h007FFF; mix[6] = 24'h0180FF; mix[7] = 24'hFE7F80;
        mix[8] = 24'h123480; mix[9] = 24'h12347F;
        rpat = 8'b1011_0010;
        do_clr();
        k = 0;
        s_valid = 1'b1; s_data = mix[0]; s_signed = 1'b0; m_ready = rpat[0];
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(negedge clk);
            r = dr[0];
            @(posedge clk);
            if (r) k++;
            #1;
            s_data = mix[k % 10];
            s_signed = k[0] ^ k[2];
            m_ready = rpat[(cyc + 1) % 8];
        end
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Asynchronous reset mid-burst
        do_clr();
        m_ready = 1'b1; s_signed = 1'b1; s_data = 24'h7FFFFF;
        @(posedge clk); #1;
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_sat_before", ds[3], 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_vld0_async", dv[0], 0);
        chk("t6_vld3_async", dv[3], 0);
        chk("t6_sat_async", ds[3], 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("t6_rdy_in_rst", dr[0], 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rdy_after", dr[0], 1);
        chk("t6_sat_after", ds[3], 0);
        run_vec("t6_first", 24'h000005, 1'b1, 0, 24'h000005, 1'b0);
        chk("t6_first_chan", dc[0], 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
